// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end: data width, NOP encoding,
// default reset address and the fetch FSM state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_gen.sv
// Address arithmetic for fetch: sequential next address and branch target.
module pc_gen
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] pc_fetch,
  input  logic [XLEN-1:0] pc_out,
  input  logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] branch_target
);

  assign pc_next       = pc_fetch + XLEN'(4);
  assign branch_target = pc_out + imm_ext;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding memory request, 1-entry skid, branch redirect.
// FETCH_MISALIGN_TRAP_EN: misaligned redirect target halts fetch and sets misalign_err.
//
// state    | meaning
// ST_IDLE  | no request; leaves for ST_REQ unless halted by a misalign trap
// ST_REQ   | request outstanding at pc_fetch
// ST_HOLD  | response parked in skid, waiting for decode to free the slot
// ST_DRAIN | redirected while a response is in flight; drop it, then refetch
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_src,
  input  logic [31:0] imm_ext,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        misalign_err
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc_fetch;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] target_raw;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic            req_q;
  logic            consume;
  logic            redirect;
  logic            trap;

  pc_gen u_pc_gen (
    .pc_fetch      (pc_fetch),
    .pc_out        (pc_out),
    .imm_ext       (imm_ext),
    .pc_next       (pc_next),
    .branch_target (target_raw)
  );

  assign consume  = instr_valid && !stall;
  assign redirect = pc_src && consume;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target = target_raw;
  assign trap   = redirect && (target_raw[1:0] != 2'b00);
`else
  assign target       = target_raw & ~32'h3;
  assign trap         = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign imem_req  = req_q;
  assign imem_addr = pc_fetch;
  assign pc_plus4  = pc_out + XLEN'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc_fetch    <= RESET_PC;
      req_q       <= 1'b0;
      instr       <= NOP_INSTR;
      pc_out      <= RESET_PC;
      instr_valid <= 1'b0;
      skid_instr  <= '0;
      skid_pc     <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      // a consumed slot empties unless a branch below refills it
      if (consume) instr_valid <= 1'b0;
      if (trap) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_err <= 1'b1;
`endif
        state       <= ST_IDLE;
        req_q       <= 1'b0;
        instr_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!misalign_err) begin
              state <= ST_REQ;
              req_q <= 1'b1;
            end
          end
          ST_REQ: begin
            if (redirect) begin
              pc_fetch    <= target;
              instr_valid <= 1'b0;
              state       <= imem_valid ? ST_REQ : ST_DRAIN;
              req_q       <= imem_valid;
            end else if (imem_valid) begin
              pc_fetch <= pc_next;
              if (!instr_valid || consume) begin
                instr       <= imem_rdata;
                pc_out      <= pc_fetch;
                instr_valid <= 1'b1;
              end else begin
                skid_instr <= imem_rdata;
                skid_pc    <= pc_fetch;
                state      <= ST_HOLD;
                req_q      <= 1'b0;
              end
            end
          end
          ST_HOLD: begin
            if (redirect) begin
              pc_fetch    <= target;
              instr_valid <= 1'b0;
              state       <= ST_REQ;
              req_q       <= 1'b1;
            end else if (consume) begin
              instr       <= skid_instr;
              pc_out      <= skid_pc;
              instr_valid <= 1'b1;
              state       <= ST_REQ;
              req_q       <= 1'b1;
            end
          end
          ST_DRAIN: begin
            if (imem_valid) begin
              state <= ST_REQ;
              req_q <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            req_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle memory model; a second instance
// starts at 0xFFFF_FFFC to exercise fetch address wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_src;
  logic [31:0] imm_ext;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        misalign_err;

  logic        w_pc_src  = 1'b0;
  logic [31:0] w_imm_ext = 32'h0;
  logic        w_stall   = 1'b0;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_rdata;
  logic        w_imem_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc_out;
  logic [31:0] w_pc_plus4;
  logic        w_instr_valid;
  logic        w_misalign_err;

  int n_chk = 0;
  int n_bad = 0;
  int cyc;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .pc_src       (pc_src),
    .imm_ext      (imm_ext),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .instr        (instr),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4),
    .instr_valid  (instr_valid),
    .misalign_err (misalign_err)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk          (clk),
    .rst          (rst),
    .pc_src       (w_pc_src),
    .imm_ext      (w_imm_ext),
    .stall        (w_stall),
    .imem_req     (w_imem_req),
    .imem_addr    (w_imem_addr),
    .imem_rdata   (w_imem_rdata),
    .imem_valid   (w_imem_valid),
    .instr        (w_instr),
    .pc_out       (w_pc_out),
    .pc_plus4     (w_pc_plus4),
    .instr_valid  (w_instr_valid),
    .misalign_err (w_misalign_err)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], 16'hBEEF};
  endfunction

  // memory answers one cycle after it sees a request, one beat per request
  always @(posedge clk) begin
    if (rst) begin
      imem_valid   <= 1'b0;
      imem_rdata   <= 32'h0;
      w_imem_valid <= 1'b0;
      w_imem_rdata <= 32'h0;
    end else begin
      imem_valid   <= imem_req && !imem_valid;
      imem_rdata   <= mem_data(imem_addr);
      w_imem_valid <= w_imem_req && !w_imem_valid;
      w_imem_rdata <= mem_data(w_imem_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_iv(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!instr_valid && n < 20);
    chk("iv_wait", {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    pc_src  = 1'b0;
    stall   = 1'b0;
    imm_ext = 32'h0;
    tick();
    tick();
    chk("rst_req",      {31'b0, imem_req},     32'd0);
    chk("rst_addr",     imem_addr,             32'h0);
    chk("rst_instr",    instr,                 32'h0000_0013);
    chk("rst_pc_out",   pc_out,                32'h0);
    chk("rst_pc_plus4", pc_plus4,              32'h4);
    chk("rst_iv",       {31'b0, instr_valid},  32'd0);
    chk("rst_mis",      {31'b0, misalign_err}, 32'd0);
    chk("rst_w_addr",   w_imem_addr,           32'hFFFF_FFFC);
    rst = 1'b0;
  endtask

  initial begin
    // sequential fetch, 1-cycle memory, no stall
    do_reset();
    tick();
    chk("seq_req1",  {31'b0, imem_req}, 32'd1);
    chk("seq_addr0", imem_addr, 32'h0);
    wait_iv(cyc);
    chk("seq_pc0",     pc_out,   32'h0);
    chk("seq_instr0",  instr,    mem_data(32'h0));
    chk("seq_plus4_0", pc_plus4, 32'h4);
    chk("seq_addr1",   imem_addr, 32'h4);
    chk("wrap_pc_out", w_pc_out,    32'hFFFF_FFFC);
    chk("wrap_plus4",  w_pc_plus4,  32'h0);
    chk("wrap_addr1",  w_imem_addr, 32'h0);
    wait_iv(cyc);
    chk("seq_rate",   cyc,    32'd2);
    chk("seq_pc1",    pc_out, 32'h4);
    chk("seq_instr1", instr,  mem_data(32'h4));
    wait_iv(cyc);
    chk("seq_pc2",   pc_out,    32'h8);
    chk("seq_addr3", imem_addr, 32'hC);

    // decode stalls for 5 cycles with a response arriving into the skid
    do_reset();
    tick();
    wait_iv(cyc);
    stall = 1'b1;
    tick();
    chk("stl_iv",  {31'b0, instr_valid}, 32'd1);
    tick();
    chk("stl_req_hold", {31'b0, imem_req}, 32'd0);
    chk("stl_pc_hold",  pc_out, 32'h0);
    repeat (3) tick();
    chk("stl_instr_hold", instr, mem_data(32'h0));
    stall = 1'b0;
    tick();
    chk("stl_rel_pc",    pc_out, 32'h4);
    chk("stl_rel_instr", instr,  mem_data(32'h4));
    chk("stl_rel_req",   {31'b0, imem_req}, 32'd1);
    chk("stl_rel_addr",  imem_addr, 32'h8);
    wait_iv(cyc);
    chk("stl_next_pc",    pc_out, 32'h8);
    chk("stl_next_instr", instr,  mem_data(32'h8));

    // backward branch from 0x10 with a request in flight
    do_reset();
    tick();
    repeat (5) wait_iv(cyc);
    chk("br_at_pc", pc_out, 32'h10);
    pc_src  = 1'b1;
    imm_ext = 32'hFFFF_FFF8;
    tick();
    pc_src = 1'b0;
    chk("br_drain_req", {31'b0, imem_req},    32'd0);
    chk("br_drain_iv",  {31'b0, instr_valid}, 32'd0);
    tick();
    chk("br_req",  {31'b0, imem_req}, 32'd1);
    chk("br_addr", imem_addr, 32'h8);
    wait_iv(cyc);
    chk("br_pc",    pc_out, 32'h8);
    chk("br_instr", instr,  mem_data(32'h8));

    // pc_src while stalled must not redirect
    do_reset();
    tick();
    wait_iv(cyc);
    stall   = 1'b1;
    pc_src  = 1'b1;
    imm_ext = 32'h100;
    tick();
    tick();
    chk("nsr_iv",  {31'b0, instr_valid}, 32'd1);
    chk("nsr_pc",  pc_out, 32'h0);
    stall  = 1'b0;
    pc_src = 1'b0;
    tick();
    chk("nsr_pc1", pc_out, 32'h4);
    wait_iv(cyc);
    chk("nsr_pc2", pc_out, 32'h8);

    // misaligned redirect target 0x22
    do_reset();
    tick();
    wait_iv(cyc);
    pc_src  = 1'b1;
    imm_ext = 32'h22;
    tick();
    pc_src = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_err", {31'b0, misalign_err}, 32'd1);
    chk("mis_req", {31'b0, imem_req},     32'd0);
    repeat (4) tick();
    chk("mis_req_stay", {31'b0, imem_req},     32'd0);
    chk("mis_iv_stay",  {31'b0, instr_valid},  32'd0);
    chk("mis_sticky",   {31'b0, misalign_err}, 32'd1);
`else
    chk("mis_err", {31'b0, misalign_err}, 32'd0);
    chk("mis_req", {31'b0, imem_req},     32'd0);
    tick();
    chk("mis_addr",     imem_addr, 32'h20);
    chk("mis_req_back", {31'b0, imem_req}, 32'd1);
    wait_iv(cyc);
    chk("mis_pc", pc_out, 32'h20);
`endif
    do_reset();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
